// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor sequencer (diff = a_in - b_in).
// Optional zero flag output enabled by defining SERSUB_ZERO_FLAG_EN.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERSUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bfl_q, bfl_d;
  logic             bout_q, bout_d;
`ifdef SERSUB_ZERO_FLAG_EN
  logic             or_q, or_d;
  logic             zero_q, zero_d;
`endif

  logic a0, b0;
  logic hs1_d, hs1_b;
  logic hs2_d, hs2_b;
  logic bo;

  // One bit slice: two half-subtractors chained through the borrow flop.
  always_comb begin
    a0    = a_q[0];
    b0    = b_q[0];
    hs1_d = a0 ^ b0;
    hs1_b = ~a0 & b0;
    hs2_d = hs1_d ^ bfl_q;
    hs2_b = ~hs1_d & bfl_q;
    bo    = hs1_b | hs2_b;
  end

  // Next-state, datapath and result capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bfl_d   = bfl_q;
    bout_d  = bout_q;
`ifdef SERSUB_ZERO_FLAG_EN
    or_d    = or_q;
    zero_d  = zero_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_d     = a_in;
          b_d     = b_in;
          res_d   = '0;
          cnt_d   = '0;
          bfl_d   = 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
          or_d    = 1'b0;
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {hs2_d, res_q[WIDTH-1:1]};
        bfl_d = bo;
        cnt_d = cnt_q + CNT_W'(1);
`ifdef SERSUB_ZERO_FLAG_EN
        or_d  = or_q | hs2_d;
`endif
        if (cnt_q == LAST) begin
          state_d = DONE;
          diff_d  = {hs2_d, res_q[WIDTH-1:1]};
          bout_d  = bo;
`ifdef SERSUB_ZERO_FLAG_EN
          zero_d  = ~(or_q | hs2_d);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bfl_q   <= 1'b0;
      bout_q  <= 1'b0;
`ifdef SERSUB_ZERO_FLAG_EN
      or_q    <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bfl_q   <= bfl_d;
      bout_q  <= bout_d;
`ifdef SERSUB_ZERO_FLAG_EN
      or_q    <= or_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERSUB_ZERO_FLAG_EN
  assign zero       = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl (WIDTH=8).
// Covers reset, latency, ignored start, mid-op reset, back-to-back.
module tb_serial_subtractor_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERSUB_ZERO_FLAG_EN
  logic         zero;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERSUB_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then sample until idle (bounded).
  // lat = sample index of done (1 = cycle after accept edge).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int nbusy, output int ndone,
                        output logic [W-1:0] d, output logic bo);
    lat = 0; nbusy = 0; ndone = 0; d = '0; bo = 1'b0;
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        lat = i;
        d = diff;
        bo = borrow_out;
      end
      if (!busy) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (diff !== 8'h00 || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: diff=%h bo=%b want 00 0", diff, borrow_out);
    end
`ifdef SERSUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_zero: zero=%b want 0", zero);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat, nb, nd;
    logic [W-1:0] d;
    logic bo;
    run_op(8'h5A, 8'h3C, lat, nb, nd, d, bo);
    checks++;
    if (lat !== 9 || nd !== 1) begin
      errors++;
      $display("FAIL basic_lat: lat=%0d ndone=%0d want 9 1", lat, nd);
    end
    checks++;
    if (nb !== 9) begin
      errors++;
      $display("FAIL basic_busy: busy_cycles=%0d want 9", nb);
    end
    checks++;
    if (d !== 8'h1E || bo !== 1'b0) begin
      errors++;
      $display("FAIL basic_val: diff=%h bo=%b want 1e 0", d, bo);
    end
  endtask

  task automatic test_underflow();
    int lat, nb, nd;
    logic [W-1:0] d;
    logic bo;
    run_op(8'h00, 8'h01, lat, nb, nd, d, bo);
    checks++;
    if (d !== 8'hFF || bo !== 1'b1) begin
      errors++;
      $display("FAIL underflow: diff=%h bo=%b want ff 1", d, bo);
    end
`ifdef SERSUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b0) begin
      errors++;
      $display("FAIL underflow_zero: zero=%b want 0", zero);
    end
`endif
  endtask

  task automatic test_equal();
    int lat, nb, nd;
    logic [W-1:0] d;
    logic bo;
    run_op(8'h80, 8'h80, lat, nb, nd, d, bo);
    checks++;
    if (d !== 8'h00 || bo !== 1'b0 || nd !== 1) begin
      errors++;
      $display("FAIL equal: diff=%h bo=%b nd=%0d want 00 0 1", d, bo, nd);
    end
`ifdef SERSUB_ZERO_FLAG_EN
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL equal_zero: zero=%b want 1", zero);
    end
`endif
  endtask

  task automatic test_hold();
    int lat, nb, nd;
    logic [W-1:0] d;
    logic bo;
    run_op(8'h5A, 8'h3C, lat, nb, nd, d, bo);
    tick(); tick();
    checks++;
    if (diff !== 8'h1E || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: diff=%h bo=%b want 1e 0", diff, borrow_out);
    end
    a_in = 8'h01; b_in = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++;
    if (diff !== 8'h1E || borrow_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_busy: diff=%h bo=%b busy=%b want 1e 0 1",
               diff, borrow_out, busy);
    end
    for (int i = 0; i < 40 && busy; i++) tick();
    checks++;
    if (diff !== 8'hFF || borrow_out !== 1'b1) begin
      errors++;
      $display("FAIL hold_new: diff=%h bo=%b want ff 1", diff, borrow_out);
    end
  endtask

  task automatic test_ignore_start();
    int nd;
    logic [W-1:0] d;
    logic bo;
    nd = 0; d = '0; bo = 1'b0;
    a_in = 8'h10; b_in = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) begin
        a_in = 8'hFF; b_in = 8'h00; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        nd++;
        d = diff;
        bo = borrow_out;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL ignore_ndone: ndone=%0d want 1", nd);
    end
    checks++;
    if (d !== 8'h0F || bo !== 1'b0) begin
      errors++;
      $display("FAIL ignore_val: diff=%h bo=%b want 0f 0", d, bo);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_mid_reset();
    int nd;
    nd = 0;
    a_in = 8'hAA; b_in = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 ||
        borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst: busy=%b done=%b diff=%h bo=%b want 0 0 00 0",
               busy, done, diff, borrow_out);
    end
    for (int i = 0; i < 15; i++) begin
      if (done || busy) nd++;
      tick();
    end
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL midrst_quiet: active_cycles=%0d want 0", nd);
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    int bad;
    bad = 0;
    a_in = 8'h03; b_in = 8'h05; start = 1'b1;
    tick();
    for (int i = 1; i <= 32; i++) begin
      if (done) begin
        t.push_back(i);
        if (diff !== 8'hFE || borrow_out !== 1'b1) bad++;
      end
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick();
    checks++;
    if (t.size() !== 3) begin
      errors++;
      $display("FAIL b2b_count: ndone=%0d want 3", t.size());
    end else begin
      checks++;
      if (t[0] !== 9 || t[1] !== 19 || t[2] !== 29) begin
        errors++;
        $display("FAIL b2b_times: %0d %0d %0d want 9 19 29",
                 t[0], t[1], t[2]);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_val: bad_results=%0d want 0", bad);
    end
  endtask

  task automatic test_random();
    int lat, nb, nd, bad;
    logic [W-1:0] a, b, d;
    logic bo;
    logic [W:0] g;
    bad = 0;
    for (int k = 0; k < 24; k++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if (k == 0) begin a = 8'hFF; b = 8'h00; end
      if (k == 1) begin a = 8'h00; b = 8'hFF; end
      g = {1'b0, a} - {1'b0, b};
      run_op(a, b, lat, nb, nd, d, bo);
      if (d !== g[W-1:0] || bo !== g[W] || lat !== W + 1) begin
        bad++;
        $display("FAIL rand_op: a=%h b=%h diff=%h bo=%b lat=%0d want %h %b %0d",
                 a, b, d, bo, lat, g[W-1:0], g[W], W + 1);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rand_total: bad=%0d want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_equal();
    test_hold();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
